// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
//   Handshake/data bundle between the issue logic and the HI/LO
//   multiply/divide unit.
//   master : drives start/op/rs_val/rt_val and the mthi/mtlo strobes,
//            observes busy/done/div_by_zero and the HI/LO registers.
//   slave  : the mult_div_unit side of the same signals.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative radix-2 multiply/divide unit with architectural HI/LO.
//   op: 00 mult, 01 multu, 10 div, 11 divu. Fixed 33-cycle latency from
//   the start edge to the done pulse, independent of op and operands.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - mult_div_unit_if.slave (start/op/operands, mthi/mtlo
//              strobes, busy/done/div_by_zero, hi/lo)
//   Build option:
//     MDU_MTHI_MTLO_EN - when defined, hi_we/lo_we/wdata load HI/LO while
//                        idle; otherwise those inputs are ignored.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  localparam logic [4:0] LAST_STEP = 5'd31;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [4:0]         cnt_r;
  logic               capture_s;
  logic               step_s;
  logic               fin_s;

  // Datapath state: acc holds {partial/remainder, multiplier/quotient}
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   b_r;
  logic               is_div_r;
  logic               neg_q_r;
  logic               neg_r_r;
  logic               dbz_flag_r;

  logic               busy_r;
  logic               done_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH:0]     div_diff_s;
  logic [2*WIDTH-1:0] acc_step_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_mag_s;
  logic [WIDTH-1:0]   rem_mag_s;
  logic [WIDTH-1:0]   hi_res_s;
  logic [WIDTH-1:0]   lo_res_s;

  // Two's-complement magnitude of a value that is known to be negative when neg is set
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
    logic [WIDTH-1:0] r;
    if (neg) begin
      r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state and per-state control strobes
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    step_s      = 1'b0;
    fin_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          capture_s   = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == LAST_STEP) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FIN: begin
        fin_s       = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Operand sign handling at capture: only mult/div (op[0]==0) are signed
  always_comb begin
    a_neg_s = ~bus.op[0] & bus.rs_val[WIDTH-1];
    b_neg_s = ~bus.op[0] & bus.rt_val[WIDTH-1];
    mag_a_s = magnitude(bus.rs_val, a_neg_s);
    mag_b_s = magnitude(bus.rt_val, b_neg_s);
  end

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                 (acc_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    rem_sh_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_diff_s = rem_sh_s - {1'b0, b_r};
    if (is_div_r) begin
      if (!div_diff_s[WIDTH]) begin
        acc_step_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_step_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the unsigned result; remainder follows the dividend sign
  always_comb begin
    if (neg_q_r) begin
      prod_s = ~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      prod_s = acc_r;
    end
    quo_mag_s = acc_r[WIDTH-1:0];
    rem_mag_s = acc_r[2*WIDTH-1:WIDTH];
    if (is_div_r) begin
      lo_res_s = magnitude(quo_mag_s, neg_q_r);
      hi_res_s = magnitude(rem_mag_s, neg_r_r);
    end else begin
      lo_res_s = prod_s[WIDTH-1:0];
      hi_res_s = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  // Operand capture, iteration counter and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= 5'd0;
      acc_r      <= {(2*WIDTH){1'b0}};
      b_r        <= {WIDTH{1'b0}};
      is_div_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      dbz_flag_r <= 1'b0;
    end else if (capture_s) begin
      cnt_r      <= 5'd0;
      acc_r      <= {{WIDTH{1'b0}}, mag_a_s};
      b_r        <= mag_b_s;
      is_div_r   <= bus.op[1];
      neg_q_r    <= a_neg_s ^ b_neg_s;
      neg_r_r    <= a_neg_s;
      dbz_flag_r <= bus.op[1] & (bus.rt_val == {WIDTH{1'b0}});
    end else if (step_s) begin
      cnt_r <= cnt_r + 5'd1;
      acc_r <= acc_step_s;
    end else begin
      cnt_r <= 5'd0;
    end
  end

  // Status outputs: busy spans RUN and FIN, done/div_by_zero pulse on leaving FIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      done_r <= fin_s;
      dbz_r  <= fin_s & dbz_flag_r;
      if (capture_s) begin
        busy_r <= 1'b1;
      end else if (fin_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  // Architectural HI/LO: result write at FIN, optional mthi/mtlo while idle (start wins)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (fin_s) begin
      if (!dbz_flag_r) begin
        hi_r <= hi_res_s;
        lo_r <= lo_res_s;
      end else begin
        hi_r <= hi_r;
        lo_r <= lo_r;
      end
`ifdef MDU_MTHI_MTLO_EN
    end else if ((state_r == IDLE) && !bus.start) begin
      if (bus.hi_we) begin
        hi_r <= bus.wdata;
      end else begin
        hi_r <= hi_r;
      end
      if (bus.lo_we) begin
        lo_r <= bus.wdata;
      end else begin
        lo_r <= lo_r;
      end
`endif
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

`ifndef MDU_MTHI_MTLO_EN
  logic unused_wr_s;
  assign unused_wr_s = ^{bus.hi_we, bus.lo_we, bus.wdata};
`endif

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed self-checking bench for mult_div_unit: reset, multu, mult with
//   back-to-back issue, signed/unsigned divide, busy protection, mthi/mtlo
//   behaviour for the selected build, and divide by zero.
module tb_mult_div_unit;

  logic clk;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a start for exactly one rising edge; returns 1 ns after that edge
  task automatic do_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges until done is seen (bounded); lat stays 100 on timeout
  task automatic wait_done(output int lat, output logic dbz);
    lat = 0;
    dbz = 1'b0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done === 1'b1) begin
        dbz = bus.div_by_zero;
        break;
      end
    end
  endtask

  task automatic test_reset;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL rst_dbz: got %b want 0", bus.div_by_zero); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL rst_hi: got %h want 00000000", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL rst_lo: got %h want 00000000", bus.lo); end
  endtask

  task automatic test_multu;
    int lat; logic dbz;
    do_start(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL multu_busy: got %b want 1", bus.busy); end
    wait_done(lat, dbz);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL multu_latency: got %0d want 33", lat); end
    n_cmp++; if (bus.hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", bus.lo); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_done: got %b want 0", bus.busy); end
    n_cmp++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL multu_dbz: got %b want 0", dbz); end
    @(posedge clk); #1;
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_reset_midrun;
    do_start(2'b00, 32'd5, 32'd5);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL midrst_hi: got %h want 00000000", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL midrst_lo: got %h want 00000000", bus.lo); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_stays_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_mult_back_to_back;
    int lat; logic dbz;
    do_start(2'b00, 32'hFFFFFFF9, 32'd3);
    wait_done(lat, dbz);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL mult_latency: got %0d want 33", lat); end
    n_cmp++; if (bus.hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi); end
    n_cmp++; if (bus.lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo: got %h want ffffffeb", bus.lo); end
    do_start(2'b00, 32'h80000000, 32'h80000000);
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %b want 0", bus.done); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_rise: got %b want 1", bus.busy); end
    wait_done(lat, dbz);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    n_cmp++; if (bus.hi !== 32'h40000000) begin n_fail++; $display("FAIL b2b_hi: got %h want 40000000", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h00000000) begin n_fail++; $display("FAIL b2b_lo: got %h want 00000000", bus.lo); end
  endtask

  task automatic test_divide;
    int lat; logic dbz;
    do_start(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(lat, dbz);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL div_latency: got %0d want 33", lat); end
    n_cmp++; if (bus.lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h want fffffffd", bus.lo); end
    n_cmp++; if (bus.hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h want ffffffff", bus.hi); end
    n_cmp++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL div_neg_dbz: got %b want 0", dbz); end
    do_start(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, dbz);
    n_cmp++; if (bus.lo !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf_lo: got %h want 80000000", bus.lo); end
    n_cmp++; if (bus.hi !== 32'h00000000) begin n_fail++; $display("FAIL div_ovf_hi: got %h want 00000000", bus.hi); end
    do_start(2'b11, 32'd100, 32'd7);
    wait_done(lat, dbz);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL divu_latency: got %0d want 33", lat); end
    n_cmp++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h want 0000000e", bus.lo); end
    n_cmp++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h want 00000002", bus.hi); end
  endtask

  task automatic test_busy_protect;
    int lat; logic dbz;
    do_start(2'b11, 32'd1000, 32'd9);
    repeat (5) @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.op     = 2'b00;
    bus.rs_val = 32'd3;
    bus.rt_val = 32'd3;
    bus.hi_we  = 1'b1;
    bus.lo_we  = 1'b1;
    bus.wdata  = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    n_cmp++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL busy_hi_held: got %h want 00000002", bus.hi); end
    n_cmp++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL busy_lo_held: got %h want 0000000e", bus.lo); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_run: got %b want 1", bus.busy); end
    wait_done(lat, dbz);
    n_cmp++; if (lat !== 27) begin n_fail++; $display("FAIL busy_latency: got %0d want 27", lat); end
    n_cmp++; if (bus.lo !== 32'd111) begin n_fail++; $display("FAIL busy_lo: got %h want 0000006f", bus.lo); end
    n_cmp++; if (bus.hi !== 32'd1) begin n_fail++; $display("FAIL busy_hi: got %h want 00000001", bus.hi); end
    @(posedge clk); #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_no_restart: got %b want 0", bus.busy); end
  endtask

`ifdef MDU_MTHI_MTLO_EN
  task automatic test_mthi_mtlo;
    int lat; logic dbz;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h12345678;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    n_cmp++; if (bus.hi !== 32'h12345678) begin n_fail++; $display("FAIL mtboth_hi: got %h want 12345678", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h12345678) begin n_fail++; $display("FAIL mtboth_lo: got %h want 12345678", bus.lo); end
    bus.hi_we = 1'b1; bus.wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    n_cmp++; if (bus.hi !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mthi_hi: got %h want deadbeef", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h12345678) begin n_fail++; $display("FAIL mthi_lo: got %h want 12345678", bus.lo); end
    bus.lo_we = 1'b1; bus.wdata = 32'h00000BAD;
    do_start(2'b01, 32'd2, 32'd3);
    bus.lo_we = 1'b0;
    n_cmp++; if (bus.lo !== 32'h12345678) begin n_fail++; $display("FAIL start_wins_lo: got %h want 12345678", bus.lo); end
    wait_done(lat, dbz);
    n_cmp++; if (bus.lo !== 32'd6) begin n_fail++; $display("FAIL start_wins_res: got %h want 00000006", bus.lo); end
  endtask
`else
  task automatic test_mthi_mtlo;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.hi !== 32'd1) begin n_fail++; $display("FAIL nowr_hi: got %h want 00000001", bus.hi); end
    n_cmp++; if (bus.lo !== 32'd111) begin n_fail++; $display("FAIL nowr_lo: got %h want 0000006f", bus.lo); end
  endtask
`endif

  task automatic test_div_by_zero;
    int lat; logic dbz;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
`ifdef MDU_MTHI_MTLO_EN
    bus.hi_we = 1'b1; bus.wdata = 32'h11111111;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h22222222;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    exp_hi = 32'h11111111;
    exp_lo = 32'h22222222;
`else
    exp_hi = 32'd1;
    exp_lo = 32'd111;
`endif
    do_start(2'b11, 32'd5, 32'd0);
    wait_done(lat, dbz);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL dbz_latency: got %0d want 33", lat); end
    n_cmp++; if (dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b want 1", dbz); end
    n_cmp++; if (bus.hi !== exp_hi) begin n_fail++; $display("FAIL dbz_hi: got %h want %h", bus.hi, exp_hi); end
    n_cmp++; if (bus.lo !== exp_lo) begin n_fail++; $display("FAIL dbz_lo: got %h want %h", bus.lo, exp_lo); end
    @(posedge clk); #1;
    n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_pulse: got %b want 0", bus.div_by_zero); end
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.rs_val = 32'h0;
    bus.rt_val = 32'h0;
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b0;
    bus.wdata  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_multu();
    test_reset_midrun();
    test_mult_back_to_back();
    test_divide();
    test_busy_protect();
    test_mthi_mtlo();
    test_div_by_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative HI/LO multiply/divide unit for the MIPS_32 datapath. Sits directly downstream of the register file: it takes the two read-port values (rs in `out1`, rt in `out2`) for mult/multu/div/divu, computes over multiple cycles, and holds the result in architectural HI/LO registers. mfhi/mflo read those registers; mthi/mtlo write them. Control stalls issue while `busy` is high.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to begin an operation; sampled on the rising edge.
- `op`  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu; sampled with `start`.
- `rs_val`  in  WIDTH  operand A (multiplicand / dividend); sampled with `start`.
- `rt_val`  in  WIDTH  operand B (multiplier / divisor); sampled with `start`.
- `hi_we`  in  1  mthi write strobe.
- `lo_we`  in  1  mtlo write strobe.
- `wdata`  in  WIDTH  data for mthi/mtlo.
- `busy`  out  1  operation in progress; start, hi_we and lo_we are ignored.
- `done`  out  1  one-cycle pulse: HI/LO hold the new result.
- `div_by_zero`  out  1  one-cycle pulse with `done` when a div/divu had `rt_val == 0`.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIN. A 5-bit iteration counter is used in RUN.
- IDLE: `start=1` captures `op` and both operands. For signed ops, it also captures the operand magnitudes and the result sign(s). Next state is RUN with count=0.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add on the unsigned magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract on the unsigned magnitudes.
  - After count 31 completes, the next state is FIN.
- FIN: apply the sign fix-up, write HI/LO, pulse `done`, return to IDLE.
- Multiply results: `{hi,lo}` is the full 64-bit product.
  - mult is two's-complement signed.
  - multu is unsigned.
  - Example: mult 0xFFFFFFFF × 0x00000002 gives hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- Divide results: lo = quotient, truncated toward zero; hi = remainder, carrying the sign of the dividend.
- Signed overflow: div of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0x00000000.
- Divide by zero (div or divu with rt=0):
  - Full latency is still used.
  - HI and LO stay unchanged.
  - `div_by_zero` pulses together with `done`.
- mthi/mtlo (when compiled in, see Configuration):
  - In IDLE with `busy=0`, `hi_we` loads `wdata` into hi and `lo_we` loads `wdata` into lo on the edge.
  - If both strobes are set, both registers load.
  - If `start` and a write strobe occur in the same edge, `start` wins; the write is dropped.
- `start`, `hi_we` and `lo_we` are ignored while `busy=1`.
- `hi` and `lo` do not change during RUN. They change only at FIN or on an mthi/mtlo write.

## Timing
- Reset (async assert, release synchronous to `clk`):
  - state = IDLE, counter = 0;
  - `busy=0`, `done=0`, `div_by_zero=0`;
  - `hi=0`, `lo=0`.
- Reset mid-operation aborts immediately. No partial result is written.
- Start is sampled at edge E0.
  - `busy=1` from after E0 through E33; this covers 32 RUN edges (E1–E32) and the transition into FIN.
  - At E33, HI/LO are written, `done=1` and `busy=0` for the cycle after E33.
  - Latency is a fixed 33 cycles from the start edge to `done`, for every op and operand value.
- Back-to-back: `start` asserted during the `done` cycle is accepted at that edge. `done` then drops and `busy` rises on the next cycle.
- `done` and `div_by_zero` are registered, single-cycle pulses.
- mthi/mtlo writes take effect on the sampling edge and are visible the next cycle.

## Configuration
- `MDU_MTHI_MTLO_EN` defined:
  - `hi_we`, `lo_we` and `wdata` are live, as described under Operation.
- `MDU_MTHI_MTLO_EN` not defined:
  - the write path is not built;
  - the ports remain but are ignored;
  - HI/LO change only through reset or FIN.

## Test plan
- Reset: assert `rst_n=0` mid-RUN → next sample shows busy=0, done=0, hi=0, lo=0; a new start afterwards completes normally.
- multu 0xFFFFFFFF × 0xFFFFFFFF → done exactly 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001.
- mult: -7 × 3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then start issued in the done cycle with mult 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000.
- Signed divide:
  - div -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF;
  - div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0;
  - divu 100 / 7 → lo=14, hi=2.
- Divide by zero: preload hi=0x11111111, lo=0x22222222 via mthi/mtlo; divu 5 / 0 → after 33 cycles done=1, div_by_zero=1, hi/lo unchanged.
- Busy protection:
  - start, hi_we and lo_we pulsed during RUN → ignored; the result matches the first operation only;
  - with `MDU_MTHI_MTLO_EN` undefined, hi_we in IDLE with wdata=0xDEADBEEF → hi unchanged.
